// File: rtl/thermo_convert_scheduler.sv
// Round-robin arbiter that serialises one requester's thermometer word into a shared converter and returns its result.
// Grant to done is SERIAL_INPUT_LENGTH+3 cycles (converter dependent); optional WAIT timeout under THERMO_SCHED_TIMEOUT_EN.
module thermo_convert_scheduler #(
  parameter int NUM_REQ             = 4,
  parameter int SERIAL_INPUT_LENGTH = 33,
  parameter int TIMEOUT_CYCLES      = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [NUM_REQ-1:0]                           req,
  input  logic [NUM_REQ*SERIAL_INPUT_LENGTH-1:0]       req_data,
  output logic [NUM_REQ-1:0]                           gnt,
  output logic [NUM_REQ-1:0]                           done,
  output logic [$clog2(SERIAL_INPUT_LENGTH-1):0]       result,
  output logic                                         busy,
  output logic                                         conv_start,
  output logic                                         conv_serial,
  input  logic                                         conv_valid,
  input  logic [$clog2(SERIAL_INPUT_LENGTH-1):0]       conv_result,
  output logic                                         timeout_err
);

  localparam int RES_W   = $clog2(SERIAL_INPUT_LENGTH-1) + 1;
  localparam int L       = SERIAL_INPUT_LENGTH;
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (L > TIMEOUT_CYCLES) ? L : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(L - 1);
  localparam logic [PTR_W-1:0]   LAST_REQ = PTR_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] cand_idx;
  logic             pick_vld;
  logic [L-1:0]     shreg;
  logic [CNT_W-1:0] cnt;
  int               cand;

  // Scan from the farthest offset down so the requester closest to rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

`ifdef THERMO_SCHED_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic timeout_q;
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      gnt_idx     <= '0;
      gnt         <= '0;
      done        <= '0;
      result      <= '0;
      busy        <= 1'b0;
      conv_start  <= 1'b0;
      conv_serial <= 1'b0;
      shreg       <= '0;
      cnt         <= '0;
`ifdef THERMO_SCHED_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      conv_start <= 1'b0;
      done       <= '0;
`ifdef THERMO_SCHED_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            gnt     <= ONE_HOT0 << pick_idx;
            gnt_idx <= pick_idx;
            shreg   <= req_data[int'(pick_idx)*L +: L];
            busy    <= 1'b1;
            state   <= S_START;
          end
        end
        // The first serial bit leaves together with the start pulse.
        S_START: begin
          conv_start  <= 1'b1;
          conv_serial <= shreg[L-1];
          shreg       <= {shreg[L-2:0], 1'b0};
          cnt         <= CNT_W'(1);
          state       <= S_SHIFT;
        end
        S_SHIFT: begin
          conv_serial <= shreg[L-1];
          shreg       <= {shreg[L-2:0], 1'b0};
          if (cnt == LAST_BIT) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          conv_serial <= 1'b0;
          if (conv_valid) begin
            result <= conv_result;
            done   <= gnt;
            state  <= S_RESP;
          end
`ifdef THERMO_SCHED_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            result    <= '0;
            done      <= gnt;
            timeout_q <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          gnt    <= '0;
          busy   <= 1'b0;
          rr_ptr <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + 1'b1;
          state  <= S_IDLE;
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
